// File: rtl/ro_freq_meter.sv
// rtl/ro_freq_meter.sv - ring-oscillator frequency meter: counts synchronized RO rising edges
// over a programmable window of CLK cycles.
module ro_freq_meter #(
  parameter int CW = 20,
  parameter int WW = 16
) (
  input  logic          CLK,
  input  logic          RESET_B,
  input  logic          RO_IN,
  input  logic          START,
  input  logic          ABORT,
  input  logic [WW-1:0] WINDOW,
  output logic          BUSY,
  output logic          DONE,
  output logic [CW-1:0] COUNT,
  output logic          OVF
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_GATE, S_FIN} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_s1;
  logic          r_s2;
  logic          r_s3;
  logic          w_edge;
  logic [WW-1:0] r_wlen;
  logic [WW-1:0] r_tmr;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_ovf_nxt;
  logic [CW-1:0] r_count;
  logic          r_ovf_out;

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= RO_IN;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge = r_s2 & ~r_s3;

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // r_tmr is shared: ARM counts 1->0, GATE counts wlen-1 -> 0.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (START) w_next = S_ARM;
      S_ARM: begin
        if (ABORT)              w_next = S_IDLE;
        else if (r_tmr == '0)   w_next = (r_wlen == '0) ? S_FIN : S_GATE;
      end
      S_GATE: begin
        if (ABORT)              w_next = S_IDLE;
        else if (r_tmr == '0)   w_next = S_FIN;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_ovf_nxt = r_ovf;
    if (r_state == S_GATE && w_edge) begin
      if (r_cnt == {CW{1'b1}}) w_ovf_nxt = 1'b1;
      else                     w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      r_wlen    <= '0;
      r_tmr     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_count   <= '0;
      r_ovf_out <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_wlen <= WINDOW;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_tmr  <= WW'(1);
          end
        end
        S_ARM: begin
          if (r_tmr == '0) r_tmr <= r_wlen - 1'b1;
          else             r_tmr <= r_tmr - 1'b1;
        end
        S_GATE: begin
          r_cnt <= w_cnt_nxt;
          r_ovf <= w_ovf_nxt;
          r_tmr <= r_tmr - 1'b1;
        end
        default: ;
      endcase
      // Result registers load on entry to FIN so they are valid alongside DONE.
      if (w_next == S_FIN && r_state != S_FIN) begin
        r_count   <= w_cnt_nxt;
        r_ovf_out <= w_ovf_nxt;
      end
    end
  end

  assign BUSY  = (r_state == S_ARM) || (r_state == S_GATE);
  assign DONE  = (r_state == S_FIN);
  assign COUNT = r_count;
  assign OVF   = r_ovf_out;

endmodule

// File: tb/tb_ro_freq_meter.sv
// tb/tb_ro_freq_meter.sv - scoreboard bench for ro_freq_meter with wide (CW=20) and narrow (CW=4)
// instances sharing stimulus.
module tb_ro_freq_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] window = '0;
  logic        ro_in;
  logic        busy_a, done_a, ovf_a;
  logic        busy_b, done_b, ovf_b;
  logic [19:0] count_a;
  logic [3:0]  count_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int cnt;
    int ovf;
    int cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int   ro_half = 2;
  int   ro_hc = 0;
  logic ro_tog = 1'b0;
  logic ro_static_en = 1'b0;
  logic ro_static_val = 1'b0;

  ro_freq_meter #(.CW(20), .WW(16)) dut_a (
    .CLK(clk), .RESET_B(rst_n), .RO_IN(ro_in), .START(start), .ABORT(abort),
    .WINDOW(window), .BUSY(busy_a), .DONE(done_a), .COUNT(count_a), .OVF(ovf_a)
  );

  ro_freq_meter #(.CW(4), .WW(16)) dut_b (
    .CLK(clk), .RESET_B(rst_n), .RO_IN(ro_in), .START(start), .ABORT(abort),
    .WINDOW(window), .BUSY(busy_b), .DONE(done_b), .COUNT(count_b), .OVF(ovf_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ro_hc + 1 >= ro_half) begin
      ro_hc  <= 0;
      ro_tog <= ~ro_tog;
    end else begin
      ro_hc <= ro_hc + 1;
    end
  end

  assign ro_in = ro_static_en ? ro_static_val : ro_tog;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done_a) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_done", 1, 0);
        end else begin
          e = qa.pop_front();
          chk("a_count", int'(count_a), e.cnt);
          chk("a_ovf", int'(ovf_a), e.ovf);
          chk("a_done_cycle", cyc, e.cyc);
        end
      end
      if (done_b) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_done", 1, 0);
        end else begin
          e = qb.pop_front();
          chk("b_count", int'(count_b), e.cnt);
          chk("b_ovf", int'(ovf_b), e.ovf);
          chk("b_done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic start_meas(input int win, input bit push, input bit with_abort,
                            input int ca, input int oa, input int cb, input int ob);
    @(negedge clk);
    start  = 1'b1;
    abort  = with_abort;
    window = win[15:0];
    if (push) begin
      qa.push_back('{ca, oa, cyc + 3 + win});
      qb.push_back('{cb, ob, cyc + 3 + win});
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
    qa.delete();
    qb.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_done_a", int'(done_a), 0);
    chk("rst_count_a", int'(count_a), 0);
    chk("rst_ovf_a", int'(ovf_a), 0);
    chk("rst_count_b", int'(count_b), 0);
    chk("rst_ovf_b", int'(ovf_b), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // basic count: period 4, window 100
    ro_half = 2;
    start_meas(100, 1, 0, 25, 0, 15, 1);
    drain(200);

    // zero window, then START in the cycle right after DONE
    start_meas(0, 1, 0, 0, 0, 0, 0);
    chk("zw_busy_c1", int'(busy_a), 1);
    @(negedge clk);
    chk("zw_busy_c2", int'(busy_a), 1);
    @(negedge clk);
    chk("zw_busy_c3", int'(busy_a), 0);
    start_meas(8, 1, 0, 2, 0, 2, 0);
    drain(50);

    // saturation: period 2
    ro_half = 1;
    repeat (4) @(negedge clk);
    start_meas(40, 1, 0, 20, 0, 15, 1);
    drain(100);
    start_meas(10, 1, 0, 5, 0, 5, 0);
    drain(50);

    // abort 50 cycles into GATE
    ro_half = 2;
    repeat (4) @(negedge clk);
    start_meas(1000, 0, 0, 0, 0, 0, 0);
    repeat (52) @(negedge clk);
    chk("ab_busy_before", int'(busy_a), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy_a", int'(busy_a), 0);
    chk("ab_busy_b", int'(busy_b), 0);
    chk("ab_count_a_hold", int'(count_a), 5);
    chk("ab_count_b_hold", int'(count_b), 5);
    chk("ab_ovf_b_hold", int'(ovf_b), 0);
    repeat (20) @(negedge clk);
    start_meas(40, 1, 0, 10, 0, 10, 0);
    drain(100);

    // START+ABORT together in IDLE, ignored START and WINDOW change mid-GATE
    start_meas(60, 1, 1, 15, 0, 15, 0);
    repeat (10) @(negedge clk);
    start  = 1'b1;
    window = 16'd5;
    @(negedge clk);
    start = 1'b0;
    drain(100);

    // reset mid-GATE discards the run
    start_meas(100, 0, 0, 0, 0, 0, 0);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    ro_static_en  = 1'b1;
    ro_static_val = 1'b1;
    #1;
    chk("mr_busy_a", int'(busy_a), 0);
    chk("mr_done_a", int'(done_a), 0);
    chk("mr_count_a", int'(count_a), 0);
    chk("mr_ovf_a", int'(ovf_a), 0);
    chk("mr_busy_b", int'(busy_b), 0);
    chk("mr_count_b", int'(count_b), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // static RO high, first START after reset
    start_meas(64, 1, 0, 0, 0, 0, 0);
    drain(120);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ro_freq_meter.md
RO_FREQ_METER -- requirements
Module: ro_freq_meter

Interface
REQ-001 SHALL have parameter CW, default 20: width of COUNT in bits.
REQ-002 SHALL have parameter WW, default 16: width of WINDOW in bits.
REQ-003 SHALL have port CLK, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET_B, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port RO_IN, input, 1: ring-oscillator tap from an inverter chain, asynchronous to CLK.
REQ-006 SHALL have port START, input, 1: begin a measurement; sampled in IDLE only.
REQ-007 SHALL have port ABORT, input, 1: cancel a measurement in progress.
REQ-008 SHALL have port WINDOW, input, WW: gate length in CLK cycles; latched when START is accepted.
REQ-009 SHALL have port BUSY, output, 1: high in ARM and GATE.
REQ-010 SHALL have port DONE, output, 1: one-cycle pulse when COUNT is valid.
REQ-011 SHALL have port COUNT, output, CW: RO rising edges counted in the last completed window.
REQ-012 SHALL have port OVF, output, 1: last completed window saturated.

Function
REQ-013 SHALL pass RO_IN through a 2-flop synchronizer (s1, s2) plus a history flop s3; edge strobe = s2 & ~s3.
REQ-014 SHALL count only RO frequencies below CLK/2; higher rates are out of scope and undetected.
REQ-015 SHALL implement FSM states IDLE, ARM, GATE, FIN.
REQ-016 IDLE: on START=1, latch WINDOW into wlen, clear the internal counter, and go to ARM.
REQ-017 ARM SHALL last exactly 2 cycles, ignoring the edge strobe, so the synchronizer flushes; then go to GATE.
REQ-018 If wlen = 0, ARM SHALL go directly to FIN, giving a result of COUNT = 0 and OVF = 0.
REQ-019 GATE SHALL last exactly wlen cycles and add 1 to the internal counter in each GATE cycle where the edge strobe is 1.
REQ-020 The internal counter SHALL saturate at 2^CW-1 and set an internal overflow flag on any attempted increment past it.
REQ-021 FIN SHALL last 1 cycle: load COUNT and OVF from the internal state, assert DONE, then return to IDLE.
REQ-022 Latency: START accepted in cycle t; ARM occupies t+1 and t+2; GATE occupies t+3 to t+2+wlen; DONE occurs in t+3+wlen.
REQ-023 COUNT and OVF SHALL change only in the FIN cycle and hold between measurements.
REQ-024 START while BUSY=1 SHALL be ignored; WINDOW changes after acceptance SHALL have no effect.
REQ-025 ABORT=1 in ARM or GATE SHALL return the FSM to IDLE next cycle, with no DONE and COUNT/OVF unchanged.
REQ-026 ABORT SHALL take priority over a simultaneous GATE-to-FIN transition.
REQ-027 ABORT in IDLE or FIN SHALL have no effect.
REQ-028 START and ABORT both high in IDLE SHALL start a measurement; ABORT acts from the next cycle.
REQ-029 A new START in the cycle after DONE SHALL be accepted.

Reset
REQ-030 While RESET_B=0, the FSM SHALL be in IDLE and s1, s2, s3, the internal counter, the overflow flag and wlen SHALL be 0.
REQ-031 While RESET_B=0, outputs SHALL be BUSY=0, DONE=0, COUNT=0, OVF=0.
REQ-032 Reset asserted mid-measurement SHALL discard the measurement with no DONE pulse.
REQ-033 After reset deasserts, the first START SHALL be accepted at the first rising edge with START=1.

Verification
REQ-034 Basic count: RO_IN period 4 CLK (duty 50%), WINDOW=100, START pulse -> DONE exactly 103 cycles after the START cycle, COUNT=25, OVF=0.
REQ-035 Zero window: WINDOW=0, START -> DONE 3 cycles after START, COUNT=0, OVF=0, BUSY high for 2 cycles.
REQ-036 Saturation: CW=4, RO_IN period 2 CLK, WINDOW=40 -> COUNT=15, OVF=1; next run with WINDOW=10 -> COUNT=5, OVF=0.
REQ-037 Abort: WINDOW=1000, ABORT at 50 cycles into GATE -> BUSY low next cycle, no DONE, COUNT holds the prior value; a following START runs normally.
REQ-038 Ignored START and reset: START repeated while BUSY and WINDOW changed mid-GATE -> result unchanged; RESET_B low mid-GATE -> all outputs 0 immediately, no DONE.
REQ-039 Static input: RO_IN held at 1, WINDOW=64 -> COUNT=0, DONE on schedule.
